// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream/downstream valid-ready pairs,
// flush, the stall counter and a debug view of the stage state.
interface pipe_skid_reg_if #(
  parameter int DATA_W = 64
);
  // A transfer happens on a rising clk edge where valid and ready are both 1.
  // Valid must not depend on ready; the stage's in_ready depends only on
  // its own state and never on out_ready.
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [31:0]       stall_cnt;
  logic [1:0]        state;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, stall_cnt, state
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, stall_cnt, state
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage with one skid entry: full throughput with a registered in_ready.
// Optional backpressure counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_reg #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  pipe_skid_reg_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q     = EMPTY;
  logic [DATA_W-1:0] main_q      = BUBBLE_VAL;
  logic [DATA_W-1:0] skid_q      = BUBBLE_VAL;
  logic              in_ready_q  = 1'b1;
  logic              out_valid_q = 1'b0;

  logic xfer_in;
  logic xfer_out;

  assign xfer_in  = bus.in_valid & in_ready_q;
  assign xfer_out = out_valid_q & bus.out_ready;

  // main_q is forced to BUBBLE_VAL whenever the stage empties, so it can
  // drive out_data directly without a mux.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      state_q     <= EMPTY;
      main_q      <= BUBBLE_VAL;
      skid_q      <= BUBBLE_VAL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            main_q      <= bus.in_data;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        ONE: begin
          case ({xfer_in, xfer_out})
            2'b11: main_q <= bus.in_data;
            2'b01: begin
              main_q      <= BUBBLE_VAL;
              state_q     <= EMPTY;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
            end
            2'b10: begin
              skid_q     <= bus.in_data;
              state_q    <= FULL;
              in_ready_q <= 1'b0;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (xfer_out) begin
            main_q     <= skid_q;
            skid_q     <= BUBBLE_VAL;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          main_q      <= BUBBLE_VAL;
          skid_q      <= BUBBLE_VAL;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.state     = state_q;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_q = '0;

  // Survives flush on purpose: it measures backpressure over the whole run.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_valid_q && !bus.out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the payload width (e.g. {PC, Instr}).
REQ-002 The block SHALL have parameter BUBBLE_VAL, default 0, giving the payload value presented when the stage holds no valid entry.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on posedge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream entry is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the stage accepts an entry this cycle.
REQ-008 The block SHALL have port in_data, input, DATA_W bits: the upstream payload.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the stage presents a valid entry.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream consumes the presented entry.
REQ-011 The block SHALL have port out_data, output, DATA_W bits: the presented payload.
REQ-012 The block SHALL have port stall_cnt, output, 32 bits: the backpressure cycle counter (see Configuration).

Function
REQ-013 Storage SHALL be a main register plus one skid register, with states EMPTY (none valid), ONE (main valid) and FULL (main and skid valid).
REQ-014 in_ready SHALL be driven directly from state: 1 in EMPTY or ONE, 0 in FULL, with no combinational path from out_ready.
REQ-015 A transfer in SHALL occur when in_valid and in_ready are both 1; a transfer out SHALL occur when out_valid and out_ready are both 1.
REQ-016 In EMPTY, a transfer in SHALL load main and move to ONE; with no transfer in, the stage SHALL stay in EMPTY.
REQ-017 In ONE, transfer in with transfer out SHALL load main from in_data and stay in ONE.
REQ-018 In ONE, transfer out only SHALL move to EMPTY.
REQ-019 In ONE, transfer in only SHALL load skid and move to FULL.
REQ-020 In ONE, with no transfer in or out, the stage SHALL hold its state and data.
REQ-021 In FULL, a transfer out SHALL copy skid into main and move to ONE; otherwise the stage SHALL hold.
REQ-022 out_valid SHALL be 1 in ONE and FULL and 0 in EMPTY.
REQ-023 out_data SHALL equal main in ONE and FULL, and BUBBLE_VAL in EMPTY.
REQ-024 Latency SHALL be 1 cycle from transfer in to out_valid when the stage is EMPTY.
REQ-025 Sustained throughput SHALL be one entry per cycle while out_ready stays 1.
REQ-026 Entries SHALL leave in arrival order and none SHALL be dropped or duplicated except by flush or reset.
REQ-027 out_data SHALL stay stable while out_valid is 1 and out_ready is 0.
REQ-028 flush SHALL have priority over every other input: the next state is EMPTY, main and skid load BUBBLE_VAL, and any in_valid that cycle is discarded.
REQ-029 flush asserted with out_ready SHALL still count the current out entry as consumed.
REQ-030 flush held for several cycles SHALL keep the stage in EMPTY.
REQ-031 reset and flush asserted together SHALL behave as reset.

Reset
REQ-032 On reset, state SHALL be EMPTY, main and skid SHALL be BUBBLE_VAL, out_valid SHALL be 0, out_data SHALL be BUBBLE_VAL, in_ready SHALL be 1, and stall_cnt SHALL be 0.
REQ-033 Reset asserted mid-operation, including in FULL, SHALL discard both entries within the same clock edge.
REQ-034 Before the first clock edge, registers SHALL power up to the reset values.

Configuration
REQ-035 With macro PIPE_STALL_CNT_EN defined, stall_cnt SHALL increment by 1 each cycle in which out_valid is 1 and out_ready is 0.
REQ-036 With PIPE_STALL_CNT_EN defined, stall_cnt SHALL saturate at 32'hFFFF_FFFF.
REQ-037 With PIPE_STALL_CNT_EN defined, stall_cnt SHALL be cleared by reset only and not by flush.
REQ-038 With PIPE_STALL_CNT_EN undefined, stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-039 Stream check: after reset, send 0x1..0x8 on consecutive cycles with out_ready=1 -> out_data shows 0x1..0x8 one cycle later, one per cycle, and in_ready stays 1.
REQ-040 Skid and stall check: in ONE holding 0xA, hold out_ready=0 and send 0xB -> FULL with in_ready=0 next cycle; release out_ready -> out shows 0xA then 0xB, and stall_cnt equals the stalled cycle count (macro on) or 0 (macro off).
REQ-041 Flush in FULL: with 0xA and 0xB held and in_valid=1 carrying 0xC, assert flush -> next cycle out_valid=0, out_data=BUBBLE_VAL, in_ready=1, and 0xC never appears.
REQ-042 Reset mid-stream: assert reset while in FULL with stall_cnt=5 -> next cycle EMPTY, out_valid=0, stall_cnt=0.
REQ-043 Random valid/ready: 10k cycles of random in_valid, out_ready and flush -> the scoreboard shows in-order, loss-free delivery between flushes, no output change while stalled, and no accepted entry while in_ready=0.
REQ-044 Saturation: with PIPE_STALL_CNT_EN defined, preload stall_cnt near max (force or long stall) -> stall_cnt holds at 32'hFFFF_FFFF and does not wrap.
